// File: rtl/rns_fwd_conv_if.sv
// Handshake bus for the {15,16,17} forward converter: operand side and residue side.
interface rns_fwd_conv_if;
  localparam int unsigned XW   = 12;
  localparam int unsigned R4W  = 4;
  localparam int unsigned R17W = 5;

  logic            in_valid;
  logic            in_ready;
  logic [XW-1:0]   in_x;
  logic            out_valid;
  logic            out_ready;
  logic [R4W-1:0]  out_r15;
  logic [R4W-1:0]  out_r16;
  logic [R17W-1:0] out_r17;
  logic            out_err;

  // Converter side
  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_r15, out_r16, out_r17, out_err
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_r15, out_r16, out_r17, out_err
  );
endinterface

// File: rtl/rns_fwd_conv.sv
// Sequential binary-to-residue converter for moduli {15,16,17}: one nibble per clock,
// end-around-carry accumulation for mod 15 and alternating sum for mod 17.
// Optional macro RNS_RANGE_CHECK_EN adds an out_err flag for X >= 4080.
module rns_fwd_conv (
  input  logic              clk,
  input  logic              rst,
  rns_fwd_conv_if.slave     bus_if
);
  localparam int unsigned NW   = 4;
  localparam int unsigned R17W = 5;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [NW-1:0]   n0_q, n0_d;
  logic [NW-1:0]   n1_q, n1_d;
  logic [NW-1:0]   n2_q, n2_d;
  logic [NW-1:0]   acc15_q, acc15_d;
  logic [R17W-1:0] acc17_q, acc17_d;
  logic [NW-1:0]   r15_q, r15_d;
  logic [NW-1:0]   r16_q, r16_d;
  logic [R17W-1:0] r17_q, r17_d;
`ifdef RNS_RANGE_CHECK_EN
  logic            range_q, range_d;
  logic            err_q, err_d;
`endif

  logic [NW-1:0]   nib;
  logic [NW:0]     sum15;
  logic [NW-1:0]   acc15_n;
  logic [R17W:0]   diff17;
  logic [R17W:0]   diff17_fix;
  logic [R17W:0]   sum17;
  logic [R17W:0]   sum17_fix;

  // Next-state, datapath and output-register computation
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    n0_d    = n0_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    acc15_d = acc15_q;
    acc17_d = acc17_q;
    r15_d   = r15_q;
    r16_d   = r16_q;
    r17_d   = r17_q;
`ifdef RNS_RANGE_CHECK_EN
    range_d = range_q;
    err_d   = err_q;
`endif

    // Shared mod-15 step: the nibble alternates between n1 (ACC1) and n2 (ACC2)
    nib        = (state_q == ACC2) ? n2_q : n1_q;
    sum15      = {1'b0, acc15_q} + {1'b0, nib};
    acc15_n    = sum15[NW-1:0] + NW'(sum15[NW]);
    diff17     = {1'b0, acc17_q} - {2'b00, n1_q};
    diff17_fix = diff17 + 6'd17;
    sum17      = {1'b0, acc17_q} + {2'b00, n2_q};
    sum17_fix  = sum17 - 6'd17;

    case (state_q)
      IDLE: begin
        if (bus_if.in_valid && ready_q) begin
          n0_d    = bus_if.in_x[3:0];
          n1_d    = bus_if.in_x[7:4];
          n2_d    = bus_if.in_x[11:8];
          acc15_d = bus_if.in_x[3:0];
          acc17_d = {1'b0, bus_if.in_x[3:0]};
`ifdef RNS_RANGE_CHECK_EN
          range_d = (bus_if.in_x >= 12'd4080);
`endif
          state_d = ACC1;
        end
      end
      ACC1: begin
        acc15_d = acc15_n;
        acc17_d = diff17[R17W] ? diff17_fix[R17W-1:0] : diff17[R17W-1:0];
        state_d = ACC2;
      end
      ACC2: begin
        acc15_d = acc15_n;
        acc17_d = (sum17 >= 6'd17) ? sum17_fix[R17W-1:0] : sum17[R17W-1:0];
        r15_d   = (acc15_n == 4'd15) ? 4'd0 : acc15_n;
        r16_d   = n0_q;
        r17_d   = acc17_d;
`ifdef RNS_RANGE_CHECK_EN
        err_d   = range_q;
`endif
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus_if.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and datapath registers with asynchronous abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      n0_q    <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
      acc15_q <= '0;
      acc17_q <= '0;
      r15_q   <= '0;
      r16_q   <= '0;
      r17_q   <= '0;
`ifdef RNS_RANGE_CHECK_EN
      range_q <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      n0_q    <= n0_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      acc15_q <= acc15_d;
      acc17_q <= acc17_d;
      r15_q   <= r15_d;
      r16_q   <= r16_d;
      r17_q   <= r17_d;
`ifdef RNS_RANGE_CHECK_EN
      range_q <= range_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus_if.in_ready  = ready_q;
  assign bus_if.out_valid = valid_q;
  assign bus_if.out_r15   = r15_q;
  assign bus_if.out_r16   = r16_q;
  assign bus_if.out_r17   = r17_q;
`ifdef RNS_RANGE_CHECK_EN
  assign bus_if.out_err   = err_q;
`else
  assign bus_if.out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rns_fwd_conv.sv
// Bench for rns_fwd_conv: directed literal cases, backpressure, reset abort, random traffic.
module tb_rns_fwd_conv;
  logic clk;
  logic rst;
  rns_fwd_conv_if bus ();

  rns_fwd_conv dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  int q_x[$];
  int cyc = 0;
  int acc_cyc = 0;

  bit rand_ready  = 0;
  bit fixed_ready = 1;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic int exp_err(input int x);
`ifdef RNS_RANGE_CHECK_EN
    return (x >= 4080) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // out_ready driver: fixed level or random per cycle
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end
  end

  // Monitor/compare: model queue of accepted operands, checked every cycle
  initial begin
    bit p_valid = 0, p_hs = 0;
    int p15 = 0, p16 = 0, p17 = 0, perr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q_x.delete();
        chk("rst_in_ready",  32'(bus.in_ready),  0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_r15", 32'(bus.out_r15), 0);
        chk("rst_r16", 32'(bus.out_r16), 0);
        chk("rst_r17", 32'(bus.out_r17), 0);
        chk("rst_err", 32'(bus.out_err), 0);
        p_valid = 0;
        p_hs    = 0;
      end else begin
        if (p_hs) begin
          chk("post_hs_valid", 32'(bus.out_valid), 0);
          chk("post_hs_ready", 32'(bus.in_ready), 1);
        end
        if (p_valid && !p_hs) begin
          chk("hold_valid", 32'(bus.out_valid), 1);
          chk("hold_r15", 32'(bus.out_r15), p15);
          chk("hold_r16", 32'(bus.out_r16), p16);
          chk("hold_r17", 32'(bus.out_r17), p17);
          chk("hold_err", 32'(bus.out_err), perr);
        end
        if (bus.out_valid) begin
          if (q_x.size() == 0) begin
            chk("spurious_valid", 1, 0);
          end else begin
            chk("model_r15", 32'(bus.out_r15), q_x[0] % 15);
            chk("model_r16", 32'(bus.out_r16), q_x[0] % 16);
            chk("model_r17", 32'(bus.out_r17), q_x[0] % 17);
            chk("model_err", 32'(bus.out_err), exp_err(q_x[0]));
            if (!p_valid) chk("latency", cyc - acc_cyc, 3);
          end
          chk("ready_while_valid", 32'(bus.in_ready), 0);
        end
        p_hs    = bus.out_valid && bus.out_ready;
        p_valid = bus.out_valid;
        p15     = 32'(bus.out_r15);
        p16     = 32'(bus.out_r16);
        p17     = 32'(bus.out_r17);
        perr    = 32'(bus.out_err);
        if (p_hs && q_x.size() > 0) void'(q_x.pop_front());
        if (bus.in_valid && bus.in_ready) begin
          q_x.push_back(32'(bus.in_x));
          acc_cyc = cyc;
        end
      end
    end
  end

  task automatic send(input int x);
    bit got = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = 12'(x);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_x     = 12'($urandom);
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid(output bit seen);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("valid_timeout", 0, 1);
  endtask

  task automatic send_chk(input int x, input int e15, input int e16, input int e17, input int eerr);
    bit seen;
    send(x);
    wait_valid(seen);
    if (seen) begin
      chk("lit_r15", 32'(bus.out_r15), e15);
      chk("lit_r16", 32'(bus.out_r16), e16);
      chk("lit_r17", 32'(bus.out_r17), e17);
      chk("lit_err", 32'(bus.out_err), eerr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    int x;
    int h15, h16, h17;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed literal cases
    send_chk(12'h000, 0, 0, 0, 0);
    send_chk(12'h123, 6, 3, 2, 0);
    send_chk(12'hFEF, 14, 15, 16, 0);
    send_chk(12'h0F0, 0, 0, 2, 0);
`ifdef RNS_RANGE_CHECK_EN
    send_chk(12'hFF0, 0, 0, 0, 1);
`else
    send_chk(12'hFF0, 0, 0, 0, 0);
`endif

    // Backpressure: hold out_ready low, offer a stray operand that must be ignored
    fixed_ready = 0;
    @(posedge clk);
    #1;
    send(12'h5A7);
    wait_valid(seen);
    h15 = 32'(bus.out_r15);
    h16 = 32'(bus.out_r16);
    h17 = 32'(bus.out_r17);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_x     = 12'h321;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_r15", 32'(bus.out_r15), h15);
      chk("bp_r16", 32'(bus.out_r16), h16);
      chk("bp_r17", 32'(bus.out_r17), h17);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    fixed_ready  = 1;
    repeat (4) @(posedge clk);
    #1;

    // Reset asserted in ACC2 aborts the conversion
    send(12'h9C3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1;
    send_chk(12'h9C3, 9, 3, 0, 0);

    // Random traffic with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4070, 4095))
                                      : int'($urandom_range(0, 4095));
      send(x);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Drain
    rand_ready  = 0;
    fixed_ready = 1;
    for (int i = 0; i < 50 && q_x.size() > 0; i++) @(posedge clk);
    chk("drain_empty", q_x.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
